// File: rtl/tdm_demux4_if.sv
// Bus bundle for the four-channel TDM demultiplexer: serial slot input side
// and registered per-channel output side.
interface tdm_demux4_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic [WIDTH-1:0]   in_data;
  logic               frame_start;
  logic [4*WIDTH-1:0] out_d;
  logic               out_valid;
  logic [1:0]         slot;
  logic               frame_err;

  modport master (
    output in_valid,
    output in_data,
    output frame_start,
    input  out_d,
    input  out_valid,
    input  slot,
    input  frame_err
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  frame_start,
    output out_d,
    output out_valid,
    output slot,
    output frame_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: gathers four-slot frames into shadow registers
// and publishes them all at once, flagging early frame_start as misalignment.
module tdm_demux4 #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  tdm_demux4_if.slave    bus
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              slot_q, slot_d;
  logic [3:0][WIDTH-1:0]   sh_q, sh_d;
  logic [4*WIDTH-1:0]      out_d_q, out_d_d;
  logic                    out_valid_q, out_valid_d;
  logic                    frame_err_q, frame_err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slot_q      <= 2'd0;
      sh_q        <= '0;
      out_d_q     <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      sh_q        <= sh_d;
      out_d_q     <= out_d_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    sh_d        = sh_q;
    out_d_d     = out_d_q;
    out_valid_d = 1'b0;
    frame_err_d = 1'b0;

    if (bus.in_valid) begin
      unique case (state_q)
        IDLE: begin
          // Beats without frame_start are dropped silently while hunting.
          if (bus.frame_start) begin
            sh_d[0] = bus.in_data;
            slot_d  = 2'd1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.frame_start) begin
            // Resync: the partial frame is abandoned, this beat becomes slot 0.
            frame_err_d = 1'b1;
            sh_d[0]     = bus.in_data;
            slot_d      = 2'd1;
          end else begin
            sh_d[slot_q] = bus.in_data;
            slot_d       = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
              // Channel 3 comes straight from the live beat so there is no extra cycle.
              out_d_d     = {bus.in_data, sh_q[2], sh_q[1], sh_q[0]};
              out_valid_d = 1'b1;
              state_d     = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.out_d     = out_d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4: directed scenarios plus random beats
// compared against a frame-level model built from a queue of collected beats.
module tb_tdm_demux4;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  tdm_demux4_if #(.WIDTH(W)) bus ();

  tdm_demux4 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: beats of the frame being collected, and expected outputs.
  bit          in_frame;
  logic [7:0]  coll_q[$];
  logic [31:0] exp_out;
  bit          exp_ov;
  bit          exp_err;
  logic [1:0]  exp_slot;
  int          cyc;
  int          ov_cycles[$];
  int          err_count;

  task automatic model_reset();
    in_frame = 0;
    coll_q.delete();
    exp_out  = '0;
    exp_ov   = 0;
    exp_err  = 0;
    exp_slot = 2'd0;
  endtask

  function automatic logic [35:0] got_vec();
    return {bus.out_d, bus.out_valid, bus.frame_err, bus.slot};
  endfunction

  function automatic logic [35:0] exp_vec();
    return {exp_out, exp_ov, exp_err, exp_slot};
  endfunction

  // Drive one cycle (inputs set just after an edge), advance the model on the
  // next edge, then leave time 1 unit after that edge for sampling.
  task automatic beat(input bit v, input bit fs, input logic [7:0] d);
    bus.in_valid    = v;
    bus.frame_start = fs;
    bus.in_data     = d;
    @(posedge clk);
    exp_ov  = 0;
    exp_err = 0;
    if (v) begin
      if (fs) begin
        if (in_frame) exp_err = 1;
        coll_q.delete();
        coll_q.push_back(d);
        in_frame = 1;
      end else if (in_frame) begin
        coll_q.push_back(d);
        if (coll_q.size() == 4) begin
          exp_out  = {coll_q[3], coll_q[2], coll_q[1], coll_q[0]};
          exp_ov   = 1;
          in_frame = 0;
          coll_q.delete();
        end
      end
    end
    exp_slot = in_frame ? 2'(coll_q.size()) : 2'd0;
    cyc++;
    #1;
    if (bus.out_valid) ov_cycles.push_back(cyc);
    if (bus.frame_err) err_count++;
  endtask

  task automatic idle();
    beat(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    bus.in_data     = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_vec() !== 36'd0) begin
      failures++;
      $display("FAIL reset_state: got %h required %h", got_vec(), 36'd0);
    end
    #2 rst_n = 1'b1;
  endtask

  task automatic test_one_frame();
    logic [7:0] data [4];
    logic [1:0] slot_seq [4];
    data     = '{8'h11, 8'h22, 8'h33, 8'h44};
    slot_seq = '{2'd1, 2'd2, 2'd3, 2'd0};
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, data[i]);
      checks++;
      if (bus.slot !== slot_seq[i]) begin
        failures++;
        $display("FAIL one_frame_slot beat%0d: got %0d required %0d", i, bus.slot, slot_seq[i]);
      end
    end
    checks++;
    if (bus.out_d !== 32'h44332211 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL one_frame_out: got out_d=%h ov=%b required 44332211 ov=1", bus.out_d, bus.out_valid);
    end
    beat(1'b0, 1'b0, 8'h00);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_d !== 32'h44332211) begin
      failures++;
      $display("FAIL one_frame_pulse: got ov=%b out_d=%h required ov=0 out_d=44332211", bus.out_valid, bus.out_d);
    end
  endtask

  task automatic test_stalls();
    logic [7:0] data [4];
    int n_ov;
    data = '{8'h11, 8'h22, 8'h33, 8'h44};
    n_ov = ov_cycles.size();
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, data[i]);
      for (int s = 0; s < 3; s++) begin
        idle();
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL stalls beat%0d stall%0d: got %h required %h", i, s, got_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (bus.out_d !== 32'h44332211 || ov_cycles.size() - n_ov != 1) begin
      failures++;
      $display("FAIL stalls_out: got out_d=%h pulses=%0d required 44332211 pulses=1", bus.out_d, ov_cycles.size() - n_ov);
    end
  endtask

  task automatic test_misalign();
    logic [7:0] data [6];
    bit         fs   [6];
    int e0, n_ov;
    data = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3};
    fs   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    e0   = err_count;
    n_ov = ov_cycles.size();
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, fs[i], data[i]);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL misalign beat%0d: got %h required %h", i, got_vec(), exp_vec());
      end
      if (i == 2) begin
        checks++;
        if (bus.frame_err !== 1'b1) begin
          failures++;
          $display("FAIL misalign_err: got frame_err=%b required 1 after B0", bus.frame_err);
        end
      end
    end
    idle();
    checks++;
    if (bus.out_d !== 32'hB3B2B1B0 || err_count - e0 != 1 || ov_cycles.size() - n_ov != 1) begin
      failures++;
      $display("FAIL misalign_out: got out_d=%h errs=%0d pulses=%0d required B3B2B1B0 errs=1 pulses=1",
               bus.out_d, err_count - e0, ov_cycles.size() - n_ov);
    end
  endtask

  task automatic test_hunting();
    logic [7:0] data [6];
    int e0;
    data = '{8'h55, 8'h66, 8'h01, 8'h02, 8'h03, 8'h04};
    e0   = err_count;
    for (int i = 0; i < 6; i++) begin
      beat(1'b1, i == 2, data[i]);
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL hunting beat%0d: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.out_d !== 32'h04030201 || err_count != e0) begin
      failures++;
      $display("FAIL hunting_out: got out_d=%h errs=%0d required 04030201 errs=0", bus.out_d, err_count - e0);
    end
  endtask

  task automatic test_back_to_back();
    int n_ov;
    idle();
    n_ov = ov_cycles.size();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        beat(1'b1, i == 0, 8'($urandom));
        checks++;
        if (got_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL back_to_back f%0d beat%0d: got %h required %h", f, i, got_vec(), exp_vec());
        end
      end
    end
    checks++;
    if (ov_cycles.size() - n_ov != 2 ||
        ov_cycles[ov_cycles.size()-1] - ov_cycles[ov_cycles.size()-2] != 4) begin
      failures++;
      $display("FAIL back_to_back_spacing: got pulses=%0d required 2 pulses 4 cycles apart",
               ov_cycles.size() - n_ov);
    end
  endtask

  task automatic test_async_reset();
    beat(1'b1, 1'b1, 8'hC0);
    beat(1'b1, 1'b0, 8'hC1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got_vec() !== 36'd0) begin
      failures++;
      $display("FAIL async_reset: got %h required %h", got_vec(), 36'd0);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, i == 0, 8'(8'hD0 + i));
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL post_reset beat%0d: got %h required %h", i, got_vec(), exp_vec());
      end
    end
    checks++;
    if (bus.out_d !== 32'hD3D2D1D0 || bus.out_valid !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_out: got out_d=%h ov=%b required D3D2D1D0 ov=1", bus.out_d, bus.out_valid);
    end
  endtask

  task automatic test_random();
    bit v, fs;
    for (int i = 0; i < 400; i++) begin
      v  = $urandom_range(0, 9) < 7;
      fs = $urandom_range(0, 4) == 0;
      beat(v, fs, 8'($urandom));
      checks++;
      if (got_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d: got %h required %h", i, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    cyc       = 0;
    err_count = 0;
    test_reset();
    test_one_frame();
    test_stalls();
    test_misalign();
    test_hunting();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
